// File: rtl/pancham_wb_host.sv
// Wishbone initiator for the pancham MD5 slave: loads a 512-bit block, starts the core,
// polls result-ready and returns the 128-bit digest (or an error after a bus error/timeout).
module pancham_wb_host #(
  parameter int unsigned AW         = 32,
  parameter logic [31:0] BASE       = 32'h0,
  parameter int unsigned START_WAIT = 4,
  parameter int unsigned POLL_MAX   = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          msg_valid,
  output logic          msg_ready,
  input  logic [511:0]  msg_data,
  output logic          digest_valid,
  output logic [127:0]  digest,
  output logic          err,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_stb_o,
  output logic          wb_cyc_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam int unsigned WCW = (START_WAIT > 0) ? $clog2(START_WAIT + 1) : 1;
  localparam int unsigned PCW = $clog2(POLL_MAX + 1);

  localparam logic [7:0] OFF_START = 8'h00;
  localparam logic [7:0] OFF_DATA  = 8'h04;
  localparam logic [7:0] OFF_READY = 8'h44;
  localparam logic [7:0] OFF_DIG   = 8'h48;
  localparam logic [7:0] OFF_RESET = 8'h58;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_WSTART, S_WAIT, S_POLL, S_RDIG, S_DONE, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [511:0]    msg_q, msg_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic [PCW-1:0]  poll_q, poll_d;
  logic [PCW-1:0]  poll_inc;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [127:0]    digest_q, digest_d;
  logic            dv_q, dv_d;
  logic            err_q, err_d;
  logic            rdy_q, rdy_d;

  function automatic logic [AW-1:0] bus_adr(input logic [7:0] off);
    return AW'(BASE + {24'h0, off});
  endfunction

  assign poll_inc = poll_q + PCW'(1);

  // Next-state logic. Bus phase is tracked by stb_q: a cycle with stb_q low inside a bus
  // state is the mandatory gap after a termination, where the next access is launched.
  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    poll_d   = poll_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    digest_d = digest_q;
    dv_d     = 1'b0;
    err_d    = err_q;
    rdy_d    = rdy_q;

    case (state_q)
      S_IDLE: begin
        if (msg_valid && rdy_q) begin
          msg_d   = msg_data;
          cnt_d   = 5'd0;
          err_d   = 1'b0;
          rdy_d   = 1'b0;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = bus_adr(OFF_DATA);
          dat_d   = msg_data[31:0];
          state_d = S_WDATA;
        end
      end

      S_WDATA: begin
        if (stb_q && wb_err_i) begin
          stb_d   = 1'b0;
          cnt_d   = 5'd0;
          state_d = S_FAIL;
        end else if (stb_q && wb_ack_i) begin
          stb_d = 1'b0;
          cnt_d = cnt_q + 5'd1;
        end else if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          if (cnt_q == 5'd16) begin
            adr_d   = bus_adr(OFF_START);
            dat_d   = 32'd1;
            state_d = S_WSTART;
          end else begin
            adr_d = bus_adr(OFF_DATA + {2'b00, cnt_q[3:0], 2'b00});
            dat_d = msg_q[{cnt_q[3:0], 5'd0} +: 32];
          end
        end
      end

      S_WSTART: begin
        if (stb_q && wb_err_i) begin
          stb_d   = 1'b0;
          cnt_d   = 5'd0;
          state_d = S_FAIL;
        end else if (stb_q && wb_ack_i) begin
          stb_d   = 1'b0;
          wait_d  = WCW'(START_WAIT);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wait_q == '0) begin
          poll_d  = '0;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = bus_adr(OFF_READY);
          dat_d   = 32'd0;
          state_d = S_POLL;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end

      S_POLL: begin
        if (stb_q && wb_err_i) begin
          stb_d   = 1'b0;
          cnt_d   = 5'd0;
          state_d = S_FAIL;
        end else if (stb_q && wb_ack_i) begin
          stb_d = 1'b0;
          if (wb_dat_i[0]) begin
            cnt_d   = 5'd0;
            state_d = S_RDIG;
          end else begin
            poll_d = poll_inc;
            if (poll_inc == PCW'(POLL_MAX)) begin
              cnt_d   = 5'd0;
              state_d = S_FAIL;
            end
          end
        end else if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b0;
          adr_d = bus_adr(OFF_READY);
        end
      end

      // Digest words are staged in the low quarter of the (now consumed) message register
      // so the visible digest only changes on completion.
      S_RDIG: begin
        if (stb_q && wb_err_i) begin
          stb_d   = 1'b0;
          cnt_d   = 5'd0;
          state_d = S_FAIL;
        end else if (stb_q && wb_ack_i) begin
          stb_d = 1'b0;
          msg_d[{cnt_q[1:0], 5'd0} +: 32] = wb_dat_i;
          cnt_d = cnt_q + 5'd1;
        end else if (!stb_q) begin
          if (cnt_q == 5'd4) begin
            dv_d     = 1'b1;
            err_d    = 1'b0;
            digest_d = msg_q[127:0];
            state_d  = S_DONE;
          end else begin
            stb_d = 1'b1;
            we_d  = 1'b0;
            adr_d = bus_adr(OFF_DIG + {4'h0, cnt_q[1:0], 2'b00});
          end
        end
      end

      // cnt_q[0] marks that the message-reset write has terminated (either way).
      S_FAIL: begin
        if (stb_q) begin
          if (wb_ack_i || wb_err_i) begin
            stb_d = 1'b0;
            cnt_d = 5'd1;
          end
        end else if (!cnt_q[0]) begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = bus_adr(OFF_RESET);
          dat_d = 32'd1;
        end else begin
          dv_d     = 1'b1;
          err_d    = 1'b1;
          digest_d = '0;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        stb_d   = 1'b0;
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= S_IDLE;
      msg_q    <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      poll_q   <= '0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      digest_q <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      poll_q   <= poll_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      digest_q <= digest_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  assign msg_ready    = rdy_q;
  assign digest_valid = dv_q;
  assign digest       = digest_q;
  assign err          = err_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_we_o      = we_q;
  assign wb_stb_o     = stb_q;
  assign wb_cyc_o     = stb_q;
  assign wb_sel_o     = {4{stb_q}};

endmodule

// File: doc/pancham_wb_host.md
# pancham_wb_host

Wishbone initiator that drives the pancham MD5 register slave from a simple streaming host port. It accepts a 512-bit padded message block, writes it into the slave's 16 data registers and pulses start. It then polls result-ready and reads back the 128-bit digest. It sits between a DMA/host engine and the pancham slave on the same Wishbone segment and replaces software polling.

## Interface
Parameters:
- `AW`, 32, Wishbone address width.
- `BASE`, 32'h0, byte base address of the pancham slave.
- `START_WAIT`, 4, idle cycles between the start write and the first poll.
- `POLL_MAX`, 1024, maximum poll reads before timeout.

Ports:
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-low.
- `msg_valid`  in  1  host offers a message block.
- `msg_ready`  out  1  block accepted when `msg_valid & msg_ready`.
- `msg_data`  in  512  padded block; word i = `msg_data[32i+31:32i]`.
- `digest_valid`  out  1  one-cycle pulse; digest/err valid.
- `digest`  out  128  word k = `digest[32k+31:32k]`.
- `err`  out  1  qualifies `digest_valid`: bus error or timeout.
- `wb_adr_o`  out  AW  byte address.
- `wb_dat_o`  out  32  write data.
- `wb_dat_i`  in  32  read data.
- `wb_sel_o`  out  4  always 4'hF while `wb_stb_o` is high, else 0.
- `wb_we_o`, `wb_stb_o`, `wb_cyc_o`  out  1  Wishbone controls.
- `wb_ack_i`, `wb_err_i`  in  1  Wishbone terminations.

## Operation
Slave map (byte offset from BASE):
- 0x00 W: start, bit0.
- 0x04+4i: data[i], i = 0..15.
- 0x44 R: result-ready, bit0.
- 0x48+4k: digest word k, k = 0..3.
- 0x58 W: message reset, bit0.

State machine:
- IDLE. `msg_ready`=1. On handshake, latch `msg_data` into an internal 512-bit register, clear word counter and `err` → WDATA.
- WDATA: write data[cnt]. On ack: if cnt==15 → WSTART, else cnt+1.
- WSTART: write 1 to 0x00. On ack, load the wait counter with START_WAIT → WAIT.
- WAIT: decrement the wait counter; at 0 → POLL, with poll counter cleared.
- POLL: read 0x44. On ack with `wb_dat_i[0]`=1 → RDIG with k=0. On ack with bit0=0: poll counter +1. Poll counter reaching POLL_MAX → FAIL, else stay in POLL.
- RDIG: read word k into `digest[32k+31:32k]`. On ack with k==3 → DONE.
- DONE: pulse `digest_valid` with `err`=0 → IDLE.
- FAIL: write 1 to 0x58 (message reset) and ignore its termination. Then pulse `digest_valid` with `err`=1 → IDLE; `digest` holds 0.

Rules:
- Any `wb_err_i` in WDATA, WSTART, POLL or RDIG → FAIL.
- Bus transactions are single classic cycles: `cyc`/`stb`/`adr`/`we`/`dat_o` stay stable until `ack_i` or `err_i`.
- After every termination `stb` and `cyc` drop for at least one cycle. The slave's start and reset edge detectors depend on this gap.
- `msg_data` may change after the handshake; only the latched copy is used.

## Timing
- Reset (async assert, sync release): state IDLE, `msg_ready`=1, `digest_valid`=0, `err`=0, `digest`=0. All `wb_*_o`=0.
- Reset mid-transaction drops `cyc`/`stb` immediately; the in-flight message is discarded.
- With a zero-wait slave (ack in the same cycle), each transaction costs 2 cycles (access + gap).
- Latency from handshake to `digest_valid` = 32 (data) + 2 (start) + START_WAIT + 2·P (polls) + 8 (digest) + 1.
- `msg_ready` is low from the handshake cycle+1 until the cycle after `digest_valid`.
- Back-to-back blocks: a new handshake is accepted in the IDLE cycle right after DONE.
- `digest` holds its value until the next DONE or FAIL.

## Test plan
- Message "abc" padded (word0=32'h80636261, word14=32'h18, others 0) into the slave model → bus trace shows 16 writes at 0x04..0x40, then start at 0x00, then polls at 0x44. `digest` = 128'h...(MD5 "abc" = 900150983cd24fb0d6963f7d28e17f72, byte order per pancham), `err`=0.
- Zero-wait slave, result-ready after 3 polls → `digest_valid` exactly 32+2+4+6+8+1 = 53 cycles after the handshake.
- Slave never sets result-ready, POLL_MAX=8 → 8 polls, one write of 1 to 0x58, `digest_valid` with `err`=1, `digest`=0.
- `wb_err_i` on the data[5] write → no further data writes, FAIL path taken, `err`=1.
- Two back-to-back blocks with `msg_valid` held high → second handshake in the cycle after the first `digest_valid`. Every transaction is separated by a cycle with `stb`=0.
- Async reset asserted during POLL → all outputs 0 immediately, `msg_ready`=1 after release, next block completes normally.
